instr_fetch: RTL and testbench

- Fetch stage directly upstream of the immediate generator and decode in the single-cycle RISC-V core.
- Holds the PC and issues one request at a time to instruction memory over a req/gnt + rvalid handshake.
- Registers the returned word and presents it to decode with a valid/ready handshake; `instr` feeds `Imm_Gen.instr`.
- Accepts a redirect (branch/jump target) from execute, squashing any in-flight or held fetch.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 21 ++
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants, fetch state encoding and PC helpers
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        HOLD  = 2'b10
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory req/gnt + rvalid bus
interface instr_fetch_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, single-outstanding imem request, held instruction to decode
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    instr_fetch_if.master   imem,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic            discard;
    logic            req;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    // req is a register so no input reaches it combinationally; it comes up
    // one cycle after reset release and is re-armed on every entry to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            discard     <= 1'b0;
            req         <= 1'b0;
            instr       <= NOP_INSTR;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc <= align_pc(redirect_target);
                    end
                    if (req && imem.imem_gnt) begin
                        state   <= WAIT;
                        req     <= 1'b0;
                        discard <= redirect;
                    end else begin
                        req <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc <= align_pc(redirect_target);
                    end
                    if (imem.imem_rvalid) begin
                        if (discard || redirect) begin
                            discard <= 1'b0;
                            state   <= FETCH;
                            req     <= 1'b1;
                        end else begin
                            instr       <= imem.imem_rdata;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    // A redirect overrides the sequential increment even when decode consumes.
                    if (redirect || instr_ready) begin
                        pc          <= redirect ? align_pc(redirect_target) : pc + XLEN'(4);
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        state       <= FETCH;
                        req         <= 1'b1;
                    end
                end
                default: begin
                    state <= FETCH;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int          lat;
        int          hold;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [31:0] instr, pc_out, instr2, pc2;
    logic        instr_valid, instr_ready, valid2, ready2;
    logic        redirect, redirect2;
    logic [31:0] redirect_target, target2;

    instr_fetch_if ifc ();
    instr_fetch_if ifc2 ();

    instr_fetch u_dut (
        .clk(clk), .rst(rst), .imem(ifc),
        .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_target(redirect_target)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst2), .imem(ifc2),
        .instr(instr2), .pc_out(pc2), .instr_valid(valid2), .instr_ready(ready2),
        .redirect(redirect2), .redirect_target(target2)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   fails  = 0;
    int   lat    = 1;
    logic bad_data = 1'b0;
    logic saw_bad  = 1'b0;

    logic [31:0] addr_q[$];
    exp_t        exp_q[$];
    logic [31:0] obs_addr_q[$];
    exp_t        obs_q[$];
    logic [31:0] seen2[$];
    exp_t        cons2[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) + 32'h0000_0100;
    endfunction

    // Memory model for the main DUT: captures a grant, answers lat cycles later.
    initial begin
        int          pend_cnt;
        logic [31:0] pend_addr;
        logic        pend_bad;
        pend_cnt = 0;
        pend_addr = '0;
        pend_bad = 1'b0;
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (ifc.imem_req && ifc.imem_gnt) begin
                pend_addr = ifc.imem_addr;
                pend_bad  = bad_data;
                pend_cnt  = lat;
            end
            @(posedge clk);
            #1;
            ifc.imem_rvalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    ifc.imem_rvalid = 1'b1;
                    ifc.imem_rdata  = pend_bad ? BAD : mem_word(pend_addr);
                end
            end
        end
    end

    // Free-running memory and decode for the wrap-around instance.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        pend = 1'b0;
        paddr = '0;
        ifc2.imem_gnt = 1'b1;
        ifc2.imem_rvalid = 1'b0;
        ifc2.imem_rdata = '0;
        ready2 = 1'b1;
        redirect2 = 1'b0;
        target2 = '0;
        forever begin
            @(negedge clk);
            if (!rst2 && ifc2.imem_req && ifc2.imem_gnt) begin
                pend = 1'b1;
                paddr = ifc2.imem_addr;
                if (seen2.size() < 4) seen2.push_back(ifc2.imem_addr);
            end
            if (!rst2 && valid2 && ready2 && cons2.size() < 4) cons2.push_back('{pc2, instr2});
            @(posedge clk);
            #1;
            ifc2.imem_rvalid = pend;
            ifc2.imem_rdata  = mem_word(paddr);
            pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.imem_req && ifc.imem_gnt) obs_addr_q.push_back(ifc.imem_addr);
            if (instr_valid && instr_ready) obs_q.push_back('{pc_out, instr});
            if (instr_valid && instr == BAD) saw_bad = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 50) begin
            step();
            n++;
        end
        chk({name, "_valid_timeout"}, {31'b0, instr_valid}, 32'h1);
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic drain();
        exp_t o, e;
        while (obs_addr_q.size() > 0) begin
            if (addr_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_req: got addr %h expected none", obs_addr_q.pop_front());
            end else begin
                chk("req_addr", obs_addr_q.pop_front(), addr_q.pop_front());
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_consume: got pc %h instr %h expected none", o.pc, o.instr);
            end else begin
                e = exp_q.pop_front();
                chk("consume_pc", o.pc, e.pc);
                chk("consume_instr", o.instr, e.instr);
            end
        end
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{1, 0, 32'h0000_0000, mem_word(32'h0000_0000)};
        tbl[1] = '{1, 0, 32'h0000_0004, mem_word(32'h0000_0004)};
        tbl[2] = '{2, 0, 32'h0000_0008, mem_word(32'h0000_0008)};
        tbl[3] = '{3, 5, 32'h0000_000C, mem_word(32'h0000_000C)};
        tbl[4] = '{1, 1, 32'h0000_0010, mem_word(32'h0000_0010)};

        rst = 1'b1;
        rst2 = 1'b1;
        ifc.imem_gnt = 1'b1;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        repeat (3) step();
        chk("rst_req", {31'b0, ifc.imem_req}, 32'h0);
        chk("rst_addr", ifc.imem_addr, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        rst = 1'b0;
        rst2 = 1'b0;

        // Sequential fetch with varying memory latency and decode back-pressure.
        for (int i = 0; i < 5; i++) begin
            lat = tbl[i].lat;
            addr_q.push_back(tbl[i].pc);
            exp_q.push_back('{tbl[i].pc, tbl[i].instr});
            wait_valid("seq");
            for (int h = 0; h < tbl[i].hold; h++) begin
                chk("hold_instr", instr, tbl[i].instr);
                chk("hold_pc_out", pc_out, tbl[i].pc);
                chk("hold_req", {31'b0, ifc.imem_req}, 32'h0);
                chk("hold_pc", ifc.imem_addr, tbl[i].pc);
                step();
            end
            consume();
            chk("post_consume_valid", {31'b0, instr_valid}, 32'h0);
            chk("post_consume_instr", instr, NOP);
            chk("post_consume_pc", ifc.imem_addr, tbl[i].pc + 32'd4);
        end

        // Redirect while waiting; the in-flight response must be dropped.
        addr_q.push_back(32'h0000_0014);
        lat = 3;
        bad_data = 1'b1;
        step();
        redirect = 1'b1;
        redirect_target = 32'h0000_0102;
        step();
        redirect = 1'b0;
        bad_data = 1'b0;
        lat = 1;
        addr_q.push_back(32'h0000_0100);
        exp_q.push_back('{32'h0000_0100, mem_word(32'h0000_0100)});
        chk("wait_redirect_addr", ifc.imem_addr, 32'h0000_0100);
        chk("wait_redirect_req", {31'b0, ifc.imem_req}, 32'h0);
        wait_valid("redir_wait");
        chk("redir_wait_instr", instr, mem_word(32'h0000_0100));
        ifc.imem_gnt = 1'b0;
        consume();

        // Redirect and consume together in HOLD: target wins over pc+4.
        redirect = 1'b1;
        redirect_target = 32'h0000_0010;
        step();
        redirect = 1'b0;
        addr_q.push_back(32'h0000_0010);
        exp_q.push_back('{32'h0000_0010, mem_word(32'h0000_0010)});
        ifc.imem_gnt = 1'b1;
        wait_valid("hold_redir");
        redirect = 1'b1;
        redirect_target = 32'h0000_0040;
        consume();
        redirect = 1'b0;
        addr_q.push_back(32'h0000_0040);
        exp_q.push_back('{32'h0000_0040, mem_word(32'h0000_0040)});
        chk("hold_redir_addr", ifc.imem_addr, 32'h0000_0040);
        chk("hold_redir_valid", {31'b0, instr_valid}, 32'h0);
        wait_valid("after_redir");
        ifc.imem_gnt = 1'b0;
        consume();

        // Reset while a response is outstanding; the late rvalid must be ignored.
        addr_q.push_back(32'h0000_0044);
        lat = 4;
        ifc.imem_gnt = 1'b1;
        step();
        rst = 1'b1;
        ifc.imem_gnt = 1'b0;
        step();
        chk("midrst_req", {31'b0, ifc.imem_req}, 32'h0);
        chk("midrst_addr", ifc.imem_addr, 32'h0);
        chk("midrst_instr", instr, NOP);
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("stale_valid", {31'b0, instr_valid}, 32'h0);
            chk("stale_instr", instr, NOP);
        end
        chk("post_rst_addr", ifc.imem_addr, 32'h0);
        lat = 1;
        addr_q.push_back(32'h0000_0000);
        exp_q.push_back('{32'h0000_0000, mem_word(32'h0000_0000)});
        ifc.imem_gnt = 1'b1;
        wait_valid("post_rst");
        ifc.imem_gnt = 1'b0;
        consume();
        step();
        drain();
        chk("addr_q_empty", addr_q.size(), 32'h0);
        chk("exp_q_empty", exp_q.size(), 32'h0);
        chk("never_bad", {31'b0, saw_bad}, 32'h0);

        // PC wrap from FFFF_FFFC on the second instance.
        begin
            int n = 0;
            while ((seen2.size() < 3 || cons2.size() < 2) && n < 100) begin
                step();
                n++;
            end
        end
        chk("wrap_seen", seen2.size() >= 3 ? 32'h1 : 32'h0, 32'h1);
        chk("wrap_cons", cons2.size() >= 2 ? 32'h1 : 32'h0, 32'h1);
        if (seen2.size() >= 3 && cons2.size() >= 2) begin
            chk("wrap_addr0", seen2[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", seen2[1], 32'h0000_0000);
            chk("wrap_addr2", seen2[2], 32'h0000_0004);
            chk("wrap_pc0", cons2[0].pc, 32'hFFFF_FFFC);
            chk("wrap_instr0", cons2[0].instr, mem_word(32'hFFFF_FFFC));
            chk("wrap_pc1", cons2[1].pc, 32'h0000_0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
